ps2_frame_receiver: RTL
=======================

// Module: ps2_frame_receiver
// PURPOSE
//   Deserialises the PS/2 keyboard line pair (kb_clk, kb_data) into 8-bit scan codes.
//   Sits directly upstream of keyboard_controller and drives its scan_code / valid_scan_code inputs.
//   Handles input synchronisation, kb_clk glitch filtering, start/parity/stop checking and frame timeout.
//   Flags bad frames on dedicated error pulses and never forwards them downstream.
// PARAMETERS
//   SYNC_STAGES     2      flip-flop stages on kb_clk and kb_data (>=2; both lines use the same depth)
//   FILTER_LEN      8      consecutive equal samples needed before the filtered kb_clk changes (>=2)
//   TIMEOUT_CYCLES  20000  clk cycles with no falling edge, mid-frame, before the frame is aborted
// PORTS
//   clk              in   1  system clock; all logic on its rising edge
//   reset_n          in   1  asynchronous, active-low reset
//   kb_clk           in   1  raw PS/2 clock pin; asynchronous; idle high
//   kb_data          in   1  raw PS/2 data pin; asynchronous; idle high
//   scan_code        out  8  last correctly received byte; held until the next good frame
//   valid_scan_code  out  1  one-cycle pulse; scan_code is new on this same cycle
//   parity_err       out  1  one-cycle pulse: frame dropped on odd-parity failure
//   frame_err        out  1  one-cycle pulse: frame dropped on bad stop bit or timeout
// BEHAVIOUR
//   Reset: sync chains and filtered clock = 1; state = IDLE; counters = 0.
//     Reset values: scan_code = 8'h00; valid_scan_code, parity_err, frame_err = 0.
//     Reset is asynchronous, so asserting it mid-frame discards the partial frame at once.
//   Filter: a saturating counter tracks the synced kb_clk.
//     Filtered value flips only after FILTER_LEN consecutive samples differ from it.
//     Any shorter pulse is ignored.
//   Edge strobe 'fall': registered; high for one cycle after the filtered clock goes 1->0.
//     kb_data is sampled from its own sync chain in the cycle 'fall' is high.
//   FSM states: IDLE, DATA, PARITY, STOP.
//     IDLE:   on fall with data=0, clear bit_cnt and shift reg, go to DATA.
//             On fall with data=1, stay in IDLE (spurious edge, no error).
//     DATA:   on fall, shift the sample in LSB-first and increment bit_cnt (3 bits).
//             After the 8th bit, go to PARITY.
//     PARITY: on fall, store the sample. Parity is OK when the 8 data bits plus this bit hold an odd number of 1s.
//             Go to STOP.
//     STOP:   on fall, go to IDLE. Outputs are registered, so each pulse asserts on the cycle after this fall cycle:
//               stop=1 and parity OK   -> scan_code <= shift reg; valid_scan_code = 1 for one cycle.
//               stop=1 and parity bad  -> parity_err = 1 for one cycle; scan_code unchanged.
//               stop=0                 -> frame_err = 1 for one cycle (takes priority over parity_err);
//                                         scan_code unchanged.
//   Timeout: counter clears on every fall and counts while state != IDLE.
//     On reaching TIMEOUT_CYCLES-1: frame_err = 1 for one cycle, state goes to IDLE, partial data discarded.
//     Counter saturates and never wraps. A fall in the same cycle as the terminal count takes priority
//     (the frame continues).
//   Latency: from the raw kb_clk stop-bit falling edge to valid_scan_code is
//     SYNC_STAGES + FILTER_LEN + 2 cycles, +/-1 cycle.
//   Outputs: at most one of the three pulses is high in any cycle. No back-pressure; downstream must take
//     each pulse. Back-to-back frames need no idle gap beyond the PS/2 line timing.
//   Host-to-device transmission is not supported; kb_clk and kb_data are inputs only.
// TESTING (PS/2 bit period 60 us; clk 100 MHz; sim may scale TIMEOUT_CYCLES)
//   1. Frame 0x1C, parity 0, stop 1 -> one valid_scan_code pulse, scan_code = 8'h1C, no error pulses.
//   2. Frames 0xF0 then 0x1C back-to-back -> two valid pulses, carrying 8'hF0 then 8'h1C.
//   3. Frame 0x1C with parity bit 1 -> parity_err pulse once; no valid; scan_code keeps its previous value.
//   4. Frame 0x1C with stop bit 0 -> frame_err pulse once; no valid; the next good 0x32 frame is received.
//   5. 3-cycle low glitch on kb_clk while idle and inside a frame -> ignored; frame still decodes correctly.
//   6. Line stops after 5 data bits -> frame_err exactly TIMEOUT_CYCLES after the last fall;
//      a following 0x1C frame decodes correctly.
//      Also: reset_n pulsed mid-frame -> outputs return to 0 at once; the next frame decodes correctly.

Source files
------------

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: synchronises and deglitches kb_clk, then shifts in
// start/data/parity/stop bits and reports each frame as a good byte, a parity error or a frame error.
module ps2_frame_receiver #(
  parameter int unsigned SyncStages    = 2,
  parameter int unsigned FilterLen     = 8,
  parameter int unsigned TimeoutCycles = 20000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       kb_clk_i,
  input  logic       kb_data_i,
  output logic [7:0] scan_code_o,
  output logic       valid_scan_code_o,
  output logic       parity_err_o,
  output logic       frame_err_o
);

  localparam int unsigned FiltW = $clog2(FilterLen + 1);
  localparam int unsigned TmoW  = $clog2(TimeoutCycles + 1);
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FilterLen - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TimeoutCycles - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
  localparam logic [1:0] StStop   = 2'd3;

  logic [SyncStages-1:0] clk_sync_q, data_sync_q;
  logic                  kb_clk_s, kb_data_s;

  logic             filt_q, filt_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall_q, fall_d;

  logic [1:0]      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]      scan_code_q, scan_code_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;

  assign kb_clk_s  = clk_sync_q[SyncStages-1];
  assign kb_data_s = data_sync_q[SyncStages-1];

  // Filtered clock flips only after FilterLen consecutive samples disagree with it.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (kb_clk_s != filt_q) begin
      if (filt_cnt_q == FiltLast) begin
        filt_d = kb_clk_s;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tmo_cnt_d   = tmo_cnt_q;
    scan_code_d = scan_code_q;
    valid_d     = 1'b0;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;

    if (fall_q || state_q == StIdle) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TmoLast) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (fall_q && !kb_data_s) begin
          bit_cnt_d = '0;
          shift_d   = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (fall_q) begin
          shift_d   = {kb_data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall_q) begin
          parity_d = kb_data_s;
          state_d  = StStop;
        end
      end
      StStop: begin
        if (fall_q) begin
          state_d = StIdle;
          if (!kb_data_s) begin
            ferr_d = 1'b1;
          end else if (^{parity_q, shift_q}) begin
            valid_d     = 1'b1;
            scan_code_d = shift_q;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A fall on the terminal count keeps the frame alive.
    if (state_q != StIdle && !fall_q && tmo_cnt_q == TmoLast) begin
      ferr_d    = 1'b1;
      state_d   = StIdle;
      tmo_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      fall_q      <= 1'b0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      scan_code_q <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SyncStages-2:0], kb_clk_i};
      data_sync_q <= {data_sync_q[SyncStages-2:0], kb_data_i};
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      fall_q      <= fall_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_cnt_q   <= tmo_cnt_d;
      scan_code_q <= scan_code_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign scan_code_o       = scan_code_q;
  assign valid_scan_code_o = valid_q;
  assign parity_err_o      = perr_q;
  assign frame_err_o       = ferr_q;

endmodule
